cache_fill_controller: RTL and testbench

//  Shares the single 4-cycle main memory between the I-cache and D-cache.

---
 rtl/cache_fill_pkg.sv | 20 ++
 rtl/fill_word_counter.sv | 30 +++
 rtl/cache_fill_controller.sv | 158 +++++++++++++++
 tb/tb_cache_fill_controller.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/cache_fill_pkg.sv
// Shared types and constants for the cache fill controller.
//   fill_state_t    : controller FSM states
//   WORDS_PER_BLK   : words per cache block
//   CNT_W           : width of the issue/return word counters (counts 0..8)
//   BLK_OFFSET_MASK : byte-offset bits inside a block (16-byte blocks)
//   LAST_WORD       : return index that completes a block fill
package cache_fill_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL_D = 2'd1,
    FILL_I = 2'd2
  } fill_state_t;

  localparam int WORDS_PER_BLK   = 8;
  localparam int CNT_W           = 4;
  localparam int BLK_OFFSET_MASK = 2 * WORDS_PER_BLK - 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_BLK - 1);

endpackage

// File: rtl/fill_word_counter.sv
// Word counter for one side of a block fill (issue or return).
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   clr      : clear to 0 (wins over inc)
//   inc      : advance by one; ignored once the count has reached 8
//   count    : current word index, 0..8
//   done     : count has reached WORDS_PER_BLK
module fill_word_counter
  import cache_fill_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  assign done = (count == CNT_W'(WORDS_PER_BLK));

  // Saturates at WORDS_PER_BLK so a stray inc can never wrap the index.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && !done) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/cache_fill_controller.sv
// Sole master of the 4-cycle pipelined main memory. Arbitrates D-cache
// misses, I-cache misses and write-through stores, sequences 8-word block
// fills and drives the global pipeline stall while a fill is in progress.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   icache_miss/_miss_addr   : I-cache miss request and missing address
//   dcache_miss/_miss_addr   : D-cache miss request and missing address
//   store_req/_addr/_data    : write-through store from the MEM stage
//   stall_n                  : low freezes the pipeline
//   icache_fill_*/icache_wr_*: fill word bus and write enables to I-cache
//   dcache_fill_*/dcache_wr_*: fill word bus and write enables to D-cache
//   mem_addr/_data_in/_enable/_wr : memory request side
//   mem_data_out/_data_valid : memory read return side
//   fill_state               : current FSM state (observation only)
// Handshake: memory accepts one request per cycle whenever mem_enable is
// high (no back-pressure); each read returns exactly once, in order, with
// mem_data_valid high for one cycle MEM_LATENCY cycles after issue.
module cache_fill_controller
  import cache_fill_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              icache_miss,
  input  logic [ADDR_W-1:0] icache_miss_addr,
  input  logic              dcache_miss,
  input  logic [ADDR_W-1:0] dcache_miss_addr,
  input  logic              store_req,
  input  logic [ADDR_W-1:0] store_addr,
  input  logic [DATA_W-1:0] store_data,
  output logic              stall_n,
  output logic [ADDR_W-1:0] icache_fill_addr,
  output logic [DATA_W-1:0] icache_fill_data,
  output logic              icache_wr_data,
  output logic              icache_wr_tag,
  output logic [ADDR_W-1:0] dcache_fill_addr,
  output logic [DATA_W-1:0] dcache_fill_data,
  output logic              dcache_wr_data,
  output logic              dcache_wr_tag,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_enable,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_data_out,
  input  logic              mem_data_valid,
  output fill_state_t       fill_state
);

  fill_state_t       state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  issue_cnt, ret_cnt;
  logic              issue_done, ret_done;
  logic              issue_inc, ret_inc, cnt_clr;
  logic [ADDR_W-1:0] fill_addr;
  logic [DATA_W-1:0] fill_data;

  assign fill_state = state_q;

  fill_word_counter u_issue_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (issue_inc),
    .count (issue_cnt),
    .done  (issue_done)
  );

  fill_word_counter u_ret_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (ret_inc),
    .count (ret_cnt),
    .done  (ret_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
    end
  end

  // Fill word bus is shared by both caches; only the write enables differ.
  assign icache_fill_addr = fill_addr;
  assign icache_fill_data = fill_data;
  assign dcache_fill_addr = fill_addr;
  assign dcache_fill_data = fill_data;

  always_comb begin
    state_d        = state_q;
    base_d         = base_q;
    issue_inc      = 1'b0;
    ret_inc        = 1'b0;
    cnt_clr        = 1'b0;
    mem_enable     = 1'b0;
    mem_wr         = 1'b0;
    mem_addr       = '0;
    mem_data_in    = '0;
    fill_addr      = '0;
    fill_data      = '0;
    icache_wr_data = 1'b0;
    icache_wr_tag  = 1'b0;
    dcache_wr_data = 1'b0;
    dcache_wr_tag  = 1'b0;
    // A raw miss stalls in the same cycle, before the FSM has reacted.
    stall_n        = (state_q == IDLE) && !icache_miss && !dcache_miss;

    case (state_q)
      IDLE: begin
        // Counters held at 0 here; late memory returns fall through unused.
        cnt_clr = 1'b1;
        if (dcache_miss) begin
          state_d = FILL_D;
          base_d  = dcache_miss_addr & ~ADDR_W'(BLK_OFFSET_MASK);
        end else if (icache_miss) begin
          state_d = FILL_I;
          base_d  = icache_miss_addr & ~ADDR_W'(BLK_OFFSET_MASK);
        end else if (store_req) begin
          mem_enable  = 1'b1;
          mem_wr      = 1'b1;
          mem_addr    = store_addr;
          mem_data_in = store_data;
        end
      end

      FILL_D, FILL_I: begin
        if (!issue_done) begin
          mem_enable = 1'b1;
          mem_addr   = base_q + ADDR_W'({issue_cnt, 1'b0});
          issue_inc  = 1'b1;
        end
        if (mem_data_valid && !ret_done) begin
          fill_addr = base_q + ADDR_W'({ret_cnt, 1'b0});
          fill_data = mem_data_out;
          ret_inc   = 1'b1;
          if (state_q == FILL_D) dcache_wr_data = 1'b1;
          else                   icache_wr_data = 1'b1;
          // Tag goes in with the last word so the line turns valid complete.
          if (ret_cnt == LAST_WORD) begin
            if (state_q == FILL_D) dcache_wr_tag = 1'b1;
            else                   icache_wr_tag = 1'b1;
            state_d = IDLE;
            cnt_clr = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_fill_controller.sv
module tb_cache_fill_controller;
  import cache_fill_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        icache_miss = 1'b0, dcache_miss = 1'b0, store_req = 1'b0;
  logic [15:0] icache_miss_addr = '0, dcache_miss_addr = '0;
  logic [15:0] store_addr = '0, store_data = '0;
  logic        stall_n, icache_wr_data, icache_wr_tag, dcache_wr_data, dcache_wr_tag;
  logic [15:0] icache_fill_addr, icache_fill_data, dcache_fill_addr, dcache_fill_data;
  logic [15:0] mem_addr, mem_data_in, mem_data_out;
  logic        mem_enable, mem_wr, mem_data_valid;
  fill_state_t fill_state;

  cache_fill_controller dut (
    .clk              (clk),
    .rst              (rst),
    .icache_miss      (icache_miss),
    .icache_miss_addr (icache_miss_addr),
    .dcache_miss      (dcache_miss),
    .dcache_miss_addr (dcache_miss_addr),
    .store_req        (store_req),
    .store_addr       (store_addr),
    .store_data       (store_data),
    .stall_n          (stall_n),
    .icache_fill_addr (icache_fill_addr),
    .icache_fill_data (icache_fill_data),
    .icache_wr_data   (icache_wr_data),
    .icache_wr_tag    (icache_wr_tag),
    .dcache_fill_addr (dcache_fill_addr),
    .dcache_fill_data (dcache_fill_data),
    .dcache_wr_data   (dcache_wr_data),
    .dcache_wr_tag    (dcache_wr_tag),
    .mem_addr         (mem_addr),
    .mem_data_in      (mem_data_in),
    .mem_enable       (mem_enable),
    .mem_wr           (mem_wr),
    .mem_data_out     (mem_data_out),
    .mem_data_valid   (mem_data_valid),
    .fill_state       (fill_state)
  );

  // ---------------- memory model: 4-cycle pipelined reads ----------------
  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  logic [3:0]  pv = '0;
  logic [15:0] pa0 = '0, pa1 = '0, pa2 = '0, pa3 = '0;
  always @(posedge clk) begin
    pv  <= {pv[2:0], mem_enable & ~mem_wr};
    pa0 <= mem_addr;
    pa1 <= pa0;
    pa2 <= pa1;
    pa3 <= pa2;
  end
  assign mem_data_valid = pv[3];
  assign mem_data_out   = mem_fn(pa3);

  // ---------------- checking ----------------
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [15:0] rd_q[$];   // expected read issue addresses
  logic [31:0] st_q[$];   // expected stores {addr, data}
  logic [35:0] wr_q[$];   // expected {i_wr, d_wr, i_tag, d_tag, addr, data}

  always @(negedge clk) begin
    if (mem_enable && !mem_wr) begin
      if (rd_q.size() == 0) check("rd_unexpected", 1, 0);
      else                  check("rd_addr", mem_addr, rd_q.pop_front());
    end
    if (mem_wr) begin
      check("st_enable", mem_enable, 1);
      if (st_q.size() == 0) check("st_unexpected", 1, 0);
      else                  check("st_addr_data", {mem_addr, mem_data_in}, st_q.pop_front());
    end
    if (icache_wr_data || dcache_wr_data || icache_wr_tag || dcache_wr_tag) begin
      if (wr_q.size() == 0) check("wr_unexpected", 1, 0);
      else check("wr_word",
                 {icache_wr_data, dcache_wr_data, icache_wr_tag, dcache_wr_tag,
                  dcache_wr_data ? dcache_fill_addr : icache_fill_addr,
                  dcache_wr_data ? dcache_fill_data : icache_fill_data},
                 wr_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_fill(input bit is_d, input logic [15:0] addr, input int n_rd, input int n_wr);
    logic [15:0] b, a;
    bit last;
    b = addr & 16'hFFF0;
    for (int k = 0; k < n_rd; k++) rd_q.push_back(b + 16'(2 * k));
    for (int k = 0; k < n_wr; k++) begin
      a    = b + 16'(2 * k);
      last = (k == 7);
      wr_q.push_back({~is_d, is_d, last & ~is_d, last & is_d, a, mem_fn(a)});
    end
  endtask

  // Miss(es) asserted at cycle 0, held until the owning cache has its tag.
  // Optional store raised at cycle 3 and held until it is taken in IDLE.
  task automatic fill_seq(input bit do_d, input bit do_i, input logic [15:0] da,
                          input logic [15:0] ia, input bit do_st,
                          input logic [15:0] sa, input logic [15:0] sd);
    int n;
    @(posedge clk); #1;
    dcache_miss = do_d; dcache_miss_addr = da;
    icache_miss = do_i; icache_miss_addr = ia;
    if (do_d) push_fill(1'b1, da, 8, 8);
    if (do_i) push_fill(1'b0, ia, 8, 8);
    n = 13 * (int'(do_d) + int'(do_i));
    #1 check("stall_c0", stall_n, 0);
    for (int c = 1; c <= n; c++) begin
      @(posedge clk); #1;
      if (c == 13) dcache_miss = 1'b0;
      if (c == n) begin dcache_miss = 1'b0; icache_miss = 1'b0; end
      if (do_st && c == 3) begin
        store_req = 1'b1; store_addr = sa; store_data = sd;
        st_q.push_back({sa, sd});
      end
      #1;
      check("stall_n", stall_n, (c == n));
      if (c == 1) check("state_c1", fill_state, do_d ? FILL_D : FILL_I);
      if (c == 11) check("no_tag_c11", {icache_wr_tag, dcache_wr_tag}, 0);
      if (c == 12) check("tag_c12", do_d ? dcache_wr_tag : icache_wr_tag, 1);
      if (c == 25) check("tag_c25", icache_wr_tag, 1);
      if (do_st && c >= 3 && c < n) check("st_held", mem_wr, 0);
    end
    if (do_st) check("st_after_fill", mem_wr, 1);
    @(posedge clk); #1;
    store_req = 1'b0;
  endtask

  task automatic do_store(input logic [15:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    store_req = 1'b1; store_addr = a; store_data = d;
    st_q.push_back({a, d});
    #1;
    check("st_idle_wr", {mem_enable, mem_wr}, 2'b11);
    check("st_idle_stall", stall_n, 1);
    @(posedge clk); #1;
    store_req = 1'b0;
  endtask

  // D fill reset during cycle 6: reads 0..5 issued, words 0..1 returned.
  task automatic rst_mid_fill(input logic [15:0] addr);
    @(posedge clk); #1;
    dcache_miss = 1'b1; dcache_miss_addr = addr;
    push_fill(1'b1, addr, 6, 2);
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk); #1;
      if (c == 6) begin rst = 1'b1; dcache_miss = 1'b0; end
      if (c == 7) rst = 1'b0;
      #1;
      if (c >= 7) begin
        check("rst_stall", stall_n, 1);
        check("rst_state", fill_state, IDLE);
        check("rst_no_wr", {dcache_wr_data, dcache_wr_tag}, 0);
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", fill_state, IDLE);
    check("reset_stall", stall_n, 1);
    check("reset_mem", {mem_enable, mem_wr}, 0);
    check("reset_wr", {icache_wr_data, icache_wr_tag, dcache_wr_data, dcache_wr_tag}, 0);
    rst = 1'b0;

    fill_seq(1'b1, 1'b0, 16'h1236, 16'h0000, 1'b0, 16'h0, 16'h0);
    fill_seq(1'b0, 1'b1, 16'h0000, 16'h0004, 1'b0, 16'h0, 16'h0);
    fill_seq(1'b1, 1'b1, 16'h0A5C, 16'h3318, 1'b0, 16'h0, 16'h0);
    do_store(16'h2000, 16'hBEEF);
    fill_seq(1'b1, 1'b0, 16'h0456, 16'h0000, 1'b1, 16'h2002, 16'h1234);
    rst_mid_fill(16'h0100);
    fill_seq(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h0, 16'h0);
    fill_seq(1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0, 16'h0, 16'h0);
    repeat (4) begin
      fill_seq(1'($urandom_range(0, 1)), 1'b1, 16'($urandom_range(0, 16'hFFFF)),
               16'($urandom_range(0, 16'hFFFF)), 1'b0, 16'h0, 16'h0);
      do_store(16'($urandom_range(0, 16'hFFFF)) & 16'hFFFE, 16'($urandom_range(0, 16'hFFFF)));
    end

    repeat (8) @(posedge clk);
    #1;
    check("rd_q_left", rd_q.size(), 0);
    check("st_q_left", st_q.size(), 0);
    check("wr_q_left", wr_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected end of sequence");
    $fatal(1);
  end

endmodule
